// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: NOP encoding, reset PC default, next-PC select and IF/ID payload.
// No logic; imported by fetch_unit and if_id_reg.
package fetch_unit_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    PCSEL_SEQ,
    PCSEL_BR,
    PCSEL_J,
    PCSEL_JR,
    PCSEL_HOLD
  } pcsel_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  // J-format target keeps the region bits of the instruction after the jump.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads fetch payload, holds, or inserts a NOP bubble.
// Latency: one cycle. Backpressure: hold keeps contents; bubble overrides hold.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  logic   bubble,
  input  if_id_t fetch_dat,
  output if_id_t if_id_dat
);

  localparam if_id_t BUBBLE = '{inst: NOP, pc4: 32'h0, valid: 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_dat <= BUBBLE;
    end else if (bubble) begin
      if_id_dat <= BUBBLE;
    end else if (!hold) begin
      if_id_dat <= fetch_dat;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, prioritised next-PC mux, fault tracking, IF/ID register.
// Latency: imem_addr is combinational from pc; fetched word reaches IF/ID one cycle later.
// Backpressure: stall holds PC and IF/ID unless a redirect or flush is present.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fetch_fault
);

  logic [31:0] pc_q;
  logic [31:0] pc_nxt;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        fault;
  logic        fault_q;
  pcsel_e      pcsel;
  if_id_t      fetch_dat;
  if_id_t      if_id_dat;

  assign pc_plus4  = pc_q + 32'd4;
  assign redirect  = jr_en | jump_en | branch_taken;
  assign fault     = (pc_q[1:0] != 2'b00) || ((pc_q >> 2) >= IMEM_WORDS);
  assign imem_addr = pc_q;
  assign pc        = pc_q;

  always_comb begin
    pcsel = PCSEL_SEQ;
    if (jr_en) begin
      pcsel = PCSEL_JR;
    end else if (jump_en) begin
      pcsel = PCSEL_J;
    end else if (branch_taken) begin
      pcsel = PCSEL_BR;
    end else if (stall) begin
      pcsel = PCSEL_HOLD;
    end
  end

  always_comb begin
    pc_nxt = pc_plus4;
    case (pcsel)
      PCSEL_JR:   pc_nxt = jr_target;
      PCSEL_J:    pc_nxt = jump_target(if_id_dat.pc4, jump_index);
      PCSEL_BR:   pc_nxt = branch_target;
      PCSEL_HOLD: pc_nxt = pc_q;
      default:    pc_nxt = pc_plus4;
    endcase
  end

  // A faulted PC keeps advancing so a later redirect can recover the pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q <= pc_nxt;
      if (fault && !stall) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign fetch_dat = '{inst: imem_data, pc4: pc_plus4, valid: 1'b1};

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .hold      (stall),
    .bubble    (flush | redirect | (fault & ~stall)),
    .fetch_dat (fetch_dat),
    .if_id_dat (if_id_dat)
  );

  assign if_id_inst  = if_id_dat.inst;
  assign if_id_pc4   = if_id_dat.pc4;
  assign if_id_valid = if_id_dat.valid;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios then randomized traffic vs. a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          WORDS  = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_en;
  logic [25:0] jump_index;
  logic        jr_en;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fetch_fault;

  logic [31:0] mem [WORDS];
  exp_t        sb_q[$];
  exp_t        m;
  int          checks = 0;
  int          errors = 0;

  fetch_unit #(.RESET_PC(RST_PC), .IMEM_WORDS(WORDS)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_en       (jump_en),
    .jump_index    (jump_index),
    .jr_en         (jr_en),
    .jr_target     (jr_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .pc            (pc),
    .if_id_inst    (if_id_inst),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .fetch_fault   (fetch_fault)
  );

  assign imem_data = mem[imem_addr[6:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a new state, pop and compare.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      cmp("sb_pc", pc, e.pc);
      cmp("sb_imem_addr", imem_addr, e.pc);
      cmp("sb_inst", if_id_inst, e.inst);
      cmp("sb_pc4", if_id_pc4, e.pc4);
      cmp("sb_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
      cmp("sb_fault", {31'b0, fetch_fault}, {31'b0, e.fault});
    end
  end

  // Drive one cycle of inputs and predict the post-edge state from the behavioural rules.
  task automatic step(input bit rst, input bit st, input bit fl,
                      input bit br, input logic [31:0] bt,
                      input bit je, input logic [25:0] ji,
                      input bit jr, input logic [31:0] jt);
    exp_t e;
    bit   bad_pc;
    @(negedge clk);
    reset = rst; stall = st; flush = fl;
    branch_taken = br; branch_target = bt;
    jump_en = je; jump_index = ji;
    jr_en = jr; jr_target = jt;
    e = m;
    if (rst) begin
      e = '{pc: RST_PC, inst: 32'h0, pc4: 32'h0, valid: 1'b0, fault: 1'b0};
    end else begin
      bad_pc = (m.pc % 4 != 0) || (m.pc / 4 >= WORDS);
      if (jr)      e.pc = jt;
      else if (je) e.pc = (m.pc4 & 32'hF000_0000) | (32'(ji) * 4);
      else if (br) e.pc = bt;
      else if (!st) e.pc = m.pc + 32'd4;
      if (fl || jr || je || br || (!st && bad_pc)) begin
        e.inst = 32'h0; e.pc4 = 32'h0; e.valid = 1'b0;
      end else if (!st) begin
        e.inst = mem[m.pc[6:2]]; e.pc4 = m.pc + 32'd4; e.valid = 1'b1;
      end
      if (!st && bad_pc) e.fault = 1'b1;
    end
    sb_q.push_back(e);
    m = e;
  endtask

  task automatic free_cyc();
    step(0, 0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0);
  endtask

  task automatic jr_to(input logic [31:0] t, input bit st);
    step(0, st, 0, 0, 32'h0, 0, 26'h0, 1, t);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit rst, st, fl, br, je, jr;
    logic [31:0] bt, jt;
    logic [25:0] ji;
    int waited;

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    jump_en = 1'b0; jump_index = 26'h0;
    jr_en = 1'b0; jr_target = 32'h0;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h8C01_0008;
    mem[1] = 32'h0020_0880;
    mem[2] = 32'hAC01_0004;
    m = '{pc: 32'hx, inst: 32'hx, pc4: 32'hx, valid: 1'bx, fault: 1'bx};

    step(1, 0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0);
    step(1, 1, 1, 1, 32'h40, 1, 26'h5, 1, 32'h44);
    settle();
    cmp("rst_pc", pc, 32'h0);
    cmp("rst_valid", {31'b0, if_id_valid}, 32'h0);
    cmp("rst_fault", {31'b0, fetch_fault}, 32'h0);

    free_cyc();
    free_cyc();
    settle();
    cmp("seq_pc", pc, 32'h8);
    cmp("seq_pc4", if_id_pc4, 32'h8);
    step(0, 1, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0);
    settle();
    cmp("stall_pc", pc, 32'h8);
    cmp("stall_inst", if_id_inst, 32'h0020_0880);
    cmp("stall_pc4", if_id_pc4, 32'h8);
    free_cyc();
    settle();
    cmp("resume_pc", pc, 32'hC);
    cmp("resume_inst", if_id_inst, 32'hAC01_0004);

    step(0, 1, 0, 1, 32'h18, 0, 26'h0, 0, 32'h0);
    settle();
    cmp("br_stall_pc", pc, 32'h18);
    cmp("br_stall_valid", {31'b0, if_id_valid}, 32'h0);
    cmp("br_stall_inst", if_id_inst, 32'h0);

    jr_to(32'h10, 0);
    free_cyc();
    settle();
    cmp("pre_j_pc4", if_id_pc4, 32'h14);
    step(0, 0, 0, 0, 32'h0, 1, 26'h3, 1, 32'h40);
    settle();
    cmp("jr_prio_pc", pc, 32'h40);
    jr_to(32'h10, 0);
    free_cyc();
    step(0, 0, 0, 0, 32'h0, 1, 26'h3, 0, 32'h0);
    settle();
    cmp("jump_pc", pc, 32'hC);

    jr_to(32'h82, 0);
    free_cyc();
    settle();
    cmp("mis_fault", {31'b0, fetch_fault}, 32'h1);
    cmp("mis_valid", {31'b0, if_id_valid}, 32'h0);
    jr_to(32'h0, 0);
    free_cyc();
    settle();
    cmp("recover_pc", pc, 32'h4);
    cmp("recover_valid", {31'b0, if_id_valid}, 32'h1);
    cmp("sticky_fault", {31'b0, fetch_fault}, 32'h1);

    jr_to(32'hFFFF_FFFC, 0);
    free_cyc();
    settle();
    cmp("wrap_pc", pc, 32'h0);

    jr_to(32'h10, 0);
    step(0, 1, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0);
    step(1, 1, 0, 1, 32'h20, 0, 26'h0, 0, 32'h0);
    settle();
    cmp("midrst_pc", pc, RST_PC);
    cmp("midrst_inst", if_id_inst, 32'h0);
    cmp("midrst_pc4", if_id_pc4, 32'h0);
    cmp("midrst_fault", {31'b0, fetch_fault}, 32'h0);

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      br  = ($urandom_range(0, 7) == 0);
      je  = ($urandom_range(0, 9) == 0);
      jr  = ($urandom_range(0, 9) == 0);
      bt  = 32'($urandom_range(0, 35)) * 4;
      ji  = 26'($urandom_range(0, 40));
      jt  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 31)) * 4;
      step(rst, st, fl, br, bt, je, ji, jr, jt);
    end

    waited = 0;
    @(negedge clk);
    while (sb_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 32, meaning instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hazard unit request to hold PC and IF/ID.
REQ-006 SHALL have port flush  input  1  kill instruction entering IF/ID (insert bubble).
REQ-007 SHALL have port branch_taken  input  1  branch resolved taken.
REQ-008 SHALL have port branch_target  input  32  full byte address of branch destination.
REQ-009 SHALL have port jump_en  input  1  J/JAL resolved in decode.
REQ-010 SHALL have port jump_index  input  26  J-format target field.
REQ-011 SHALL have port jr_en  input  1  JR resolved.
REQ-012 SHALL have port jr_target  input  32  register-sourced target address.
REQ-013 SHALL have port imem_addr  output  32  byte address driven to instruction memory.
REQ-014 SHALL have port imem_data  input  32  instruction word returned combinationally for imem_addr.
REQ-015 SHALL have port pc  output  32  current fetch PC.
REQ-016 SHALL have port if_id_inst  output  32  registered instruction for decode.
REQ-017 SHALL have port if_id_pc4  output  32  registered PC+4 of that instruction.
REQ-018 SHALL have port if_id_valid  output  1  IF/ID holds a real instruction.
REQ-019 SHALL have port fetch_fault  output  1  sticky flag: PC misaligned or beyond IMEM_WORDS.

Function
REQ-020 SHALL drive imem_addr = pc combinationally; zero-cycle memory latency, one-cycle fetch-to-IF/ID latency.
REQ-021 SHALL compute jump target as {if_id_pc4[31:28], jump_index, 2'b00}.
REQ-022 SHALL select next PC by priority: jr_en > jump_en > branch_taken > stall (hold) > pc+4.
REQ-023 SHALL compute pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-024 Redirect (any of jr_en/jump_en/branch_taken) SHALL override stall for PC update.
REQ-025 Non-stalled, no flush/redirect: IF/ID SHALL load {imem_data, pc+4, valid=1}.
REQ-026 Stall without redirect or flush: PC and all IF/ID outputs SHALL hold.
REQ-027 flush, or any redirect: IF/ID SHALL load inst=32'h0 (NOP), pc4=0, valid=0; flush wins over stall.
REQ-028 Fault condition = pc[1:0]!=0 or pc>>2 >= IMEM_WORDS; on a non-stalled edge under fault, IF/ID SHALL load a bubble and fetch_fault SHALL set and remain 1 until reset.
REQ-029 Faulted PC SHALL still advance per REQ-022, so a redirect can recover the pipeline.
REQ-030 Simultaneous inputs SHALL resolve purely by REQ-022/REQ-027 priority; no input combination yields X.

Reset
REQ-031 On reset: pc=RESET_PC, if_id_inst=0, if_id_pc4=0, if_id_valid=0, fetch_fault=0.
REQ-032 Reset SHALL override stall, flush and every redirect in the same cycle.
REQ-033 Reset asserted mid-stall or mid-redirect SHALL discard pending state; first fetch after release is RESET_PC.

Structure
REQ-034 Shared package SHALL hold NOP encoding (32'h0), RESET_PC default, and next-PC select enumeration (PCSEL_SEQ, PCSEL_BR, PCSEL_J, PCSEL_JR, PCSEL_HOLD).
REQ-035 One sub-module SHALL be used: if_id_reg (IF/ID pipeline register with hold/bubble control); next-PC mux and PC register stay in fetch_unit.

Verification
REQ-036 Reset, then 3 free cycles with imem returning 0x8C01_0008, 0x0020_0880, 0xAC01_0004 -> pc 0,4,8,12; if_id_pc4 4,8,12; valid=1.
REQ-037 stall=1 for 2 cycles at pc=8 -> pc stays 8, IF/ID stays {0x0020_0880, 8}, then resumes at 12.
REQ-038 branch_taken=1, branch_target=0x18, stall=1 same cycle -> pc=0x18 next cycle, if_id_valid=0, if_id_inst=0.
REQ-039 jump_en=1, jump_index=26'h3, if_id_pc4=0x14, plus jr_en=1 jr_target=0x40 -> pc=0x40 (JR priority); repeat without jr_en -> pc=0x0C.
REQ-040 jr_target=0x82 (misaligned) -> fetch_fault=1 and bubble; later jr_target=0x0 -> pc=0, fetch_fault stays 1 until reset.
REQ-041 reset pulsed during stall at pc=0x10 -> next cycle pc=RESET_PC, all IF/ID outputs 0, fetch_fault=0.
